// File: rtl/snake_pkg.sv
// Shared encodings and limits for the snake game score path and its display driver.
package snake_pkg;

    localparam int SCORE_W   = 16;
    localparam int MAX_SCORE = 9999;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_PLAYING = 2'b01;
    localparam logic [1:0] ST_OVER    = 2'b10;

    // The sum is one bit wider than the score so an overflow past the ceiling is still visible.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W:0]   inc,
                                                   input logic [SCORE_W:0]   ceil);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + inc;
        return (sum > ceil) ? ceil[SCORE_W-1:0] : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/snake_alt_timer.sv
// Free-running alternation counter for the game-over display; its MSB selects score or high score.
module snake_alt_timer #(
    parameter int ALT_BITS = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic phase_o
);

    logic [ALT_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clear_i ? '0 : cnt_q + ALT_BITS'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_o = cnt_q[ALT_BITS-1];

endmodule

// File: rtl/snake_score_keeper.sv
// Score, session high score and IDLE/PLAYING/OVER sequencing for the snake game,
// plus the binary value shown on the four-digit display.
module snake_score_keeper
    import snake_pkg::*;
#(
    parameter int POINTS_PER_FOOD = 1,
    parameter int MAX_SCORE       = snake_pkg::MAX_SCORE,
    parameter int ALT_BITS        = 27
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               eat,
    input  logic               die,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [SCORE_W-1:0] display_number,
    output logic [1:0]         state,
    output logic               new_record
);

    localparam logic [SCORE_W:0] PTS  = (SCORE_W+1)'(POINTS_PER_FOOD);
    localparam logic [SCORE_W:0] CEIL = (SCORE_W+1)'(MAX_SCORE);

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               rec_q, rec_d;
    logic [SCORE_W-1:0] eat_val;
    logic               alt_clear;
    logic               alt_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_PLAYING;
            ST_PLAYING: if (die)   state_d = ST_OVER;
            ST_OVER:    if (start) state_d = ST_PLAYING;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        display_number = '0;
        case (state_q)
            ST_IDLE:    display_number = high_q;
            ST_PLAYING: display_number = score_q;
            ST_OVER:    display_number = alt_phase ? high_q : score_q;
            default:    display_number = '0;
        endcase
    end

    // An eat in the dying cycle lands first, so the record check sees the incremented score.
    always_comb begin
        score_d = score_q;
        high_d  = high_q;
        rec_d   = rec_q;
        eat_val = sat_add(score_q, PTS, CEIL);
        case (state_q)
            ST_IDLE: score_d = '0;
            ST_PLAYING: begin
                if (eat) score_d = eat_val;
                if (die) begin
                    if (score_d > high_q) begin
                        high_d = score_d;
                        rec_d  = 1'b1;
                    end else begin
                        rec_d  = 1'b0;
                    end
                end
            end
            ST_OVER: begin
                if (start) begin
                    score_d = '0;
                    rec_d   = 1'b0;
                end
            end
            default: score_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
            high_q  <= '0;
            rec_q   <= 1'b0;
        end else begin
            score_q <= score_d;
            high_q  <= high_d;
            rec_q   <= rec_d;
        end
    end

    assign alt_clear = (state_q == ST_PLAYING) && die;

    snake_alt_timer #(
        .ALT_BITS (ALT_BITS)
    ) u_alt_timer (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (alt_clear),
        .phase_o (alt_phase)
    );

    assign score      = score_q;
    assign high_score = high_q;
    assign state      = state_q;
    assign new_record = rec_q;

endmodule

// File: tb/tb_snake_score_keeper.sv
// Directed bench: unit-step instance for game flow and display alternation,
// 100-point instance for saturation at the display ceiling.
module tb_snake_score_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_start = 1'b0, a_eat = 1'b0, a_die = 1'b0;
    logic        b_start = 1'b0, b_eat = 1'b0, b_die = 1'b0;
    logic [15:0] a_score, a_high, a_disp;
    logic [15:0] b_score, b_high, b_disp;
    logic [1:0]  a_state, b_state;
    logic        a_rec, b_rec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snake_score_keeper #(
        .POINTS_PER_FOOD (1),
        .MAX_SCORE       (9999),
        .ALT_BITS        (4)
    ) dut_a (
        .clk            (clk),
        .reset          (reset),
        .start          (a_start),
        .eat            (a_eat),
        .die            (a_die),
        .score          (a_score),
        .high_score     (a_high),
        .display_number (a_disp),
        .state          (a_state),
        .new_record     (a_rec)
    );

    snake_score_keeper #(
        .POINTS_PER_FOOD (100),
        .MAX_SCORE       (9999),
        .ALT_BITS        (4)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .start          (b_start),
        .eat            (b_eat),
        .die            (b_die),
        .score          (b_score),
        .high_score     (b_high),
        .display_number (b_disp),
        .state          (b_state),
        .new_record     (b_rec)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit b, input logic s, input logic e, input logic d);
        if (b) begin
            b_start = s; b_eat = e; b_die = d;
        end else begin
            a_start = s; a_eat = e; a_die = d;
        end
    endtask

    task automatic pulse(input bit b, input logic s, input logic e, input logic d);
        @(negedge clk);
        drive(b, s, e, d);
        @(negedge clk);
        drive(b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic eat_n(input bit b, input int n);
        @(negedge clk);
        drive(b, 1'b0, 1'b1, 1'b0);
        repeat (n) @(negedge clk);
        drive(b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_a(input string tag, input logic [1:0] st, input logic [15:0] sc,
                           input logic [15:0] hi, input logic rec);
        check({tag, ".state"}, 16'(a_state), 16'(st));
        check({tag, ".score"}, a_score, sc);
        check({tag, ".high"},  a_high, hi);
        check({tag, ".rec"},   16'(a_rec), 16'(rec));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_a("reset", 2'b00, 16'd0, 16'd0, 1'b0);
        check("reset.disp", a_disp, 16'd0);

        eat_n(0, 2);
        check("idle_eat.score", a_score, 16'd0);
        pulse(0, 1'b0, 1'b0, 1'b1);
        check("idle_die.state", 16'(a_state), 16'd0);

        // Game 1: five foods, first record
        pulse(0, 1'b1, 1'b0, 1'b0);
        check_a("g1_start", 2'b01, 16'd0, 16'd0, 1'b0);
        eat_n(0, 5);
        check("g1_eat.score", a_score, 16'd5);
        check("g1_eat.disp", a_disp, 16'd5);
        pulse(0, 1'b0, 1'b0, 1'b1);
        check_a("g1_over", 2'b10, 16'd5, 16'd5, 1'b1);
        check("g1_over.disp", a_disp, 16'd5);
        eat_n(0, 1);
        check("g1_over_eat.score", a_score, 16'd5);
        repeat (7) @(negedge clk);
        check("g1_toggle.disp", a_disp, 16'd5);

        // Game 2: lower score, display alternates 3 / 5 every 8 cycles
        pulse(0, 1'b1, 1'b0, 1'b0);
        check_a("g2_start", 2'b01, 16'd0, 16'd5, 1'b0);
        eat_n(0, 3);
        pulse(0, 1'b0, 1'b0, 1'b1);
        check_a("g2_over", 2'b10, 16'd3, 16'd5, 1'b0);
        for (int k = 0; k < 17; k++) begin
            check($sformatf("g2_alt%0d", k), a_disp, ((k % 16) < 8) ? 16'd3 : 16'd5);
            @(negedge clk);
        end

        // Games 3 and 4: reach 7, then tie at 7
        pulse(0, 1'b1, 1'b0, 1'b0);
        eat_n(0, 7);
        pulse(0, 1'b0, 1'b0, 1'b1);
        check_a("g3_over", 2'b10, 16'd7, 16'd7, 1'b1);
        pulse(0, 1'b1, 1'b0, 1'b0);
        eat_n(0, 7);
        pulse(0, 1'b0, 1'b0, 1'b1);
        check_a("g4_tie", 2'b10, 16'd7, 16'd7, 1'b0);

        // Game 5: eat and die together at 7
        pulse(0, 1'b1, 1'b0, 1'b0);
        eat_n(0, 7);
        pulse(0, 1'b0, 1'b1, 1'b1);
        check_a("g5_eatdie", 2'b10, 16'd8, 16'd8, 1'b1);
        check("idle_high.disp_pre", a_disp, 16'd8);

        // Game 6: start with eat ignores the eat; start while playing ignored
        pulse(0, 1'b1, 1'b1, 1'b0);
        check_a("g6_start_eat", 2'b01, 16'd0, 16'd8, 1'b0);
        eat_n(0, 42);
        check("g6_eat.score", a_score, 16'd42);
        pulse(0, 1'b1, 1'b0, 1'b0);
        check_a("g6_restart", 2'b01, 16'd42, 16'd8, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_a("async_rst", 2'b00, 16'd0, 16'd0, 1'b0);
        check("async_rst.disp", a_disp, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        eat_n(0, 3);
        check("post_rst_eat.score", a_score, 16'd0);

        // Saturation with 100 points per food
        pulse(1, 1'b1, 1'b0, 1'b0);
        eat_n(1, 99);
        check("sat_9900.score", b_score, 16'd9900);
        eat_n(1, 1);
        check("sat_clip.score", b_score, 16'd9999);
        eat_n(1, 2);
        check("sat_hold.score", b_score, 16'd9999);
        check("sat_hold.disp", b_disp, 16'd9999);
        pulse(1, 1'b0, 1'b0, 1'b1);
        check("sat_over.high", b_high, 16'd9999);
        check("sat_over.rec", 16'(b_rec), 16'd1);
        check("sat_over.state", 16'(b_state), 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
